// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-port register file with a per-entry pending scoreboard and a
//   sequential bulk-clear engine. After reset (or clr_req) the array is swept
//   to zero one entry per clock; ready rises once the sweep has finished.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   clr_req            request bulk clear of all entries and pending bits
//   ready              1 = RUN, writes and allocations accepted
//   we/waddr/wdata     writeback port
//   raddr/rdata/rpend  NUM_RD packed read ports (combinational data + pending)
//   alloc_valid/addr   mark a register as having an in-flight producer
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     alloc_valid,
  input  logic [ADDR_W-1:0]        alloc_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DEPTH-1:0]    pend_q, pend_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Control, scoreboard and the single array write port. The sweep and the
  // writeback share the write port; the state decides who owns it.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        // All-ones counter is the last entry (DEPTH-1); counter wraps to 0.
        if (&clr_cnt_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
          ready_d   = 1'b0;
          pend_d    = '0;
        end else begin
          if (we) pend_d[waddr] = 1'b0;
          // Set after clear: a same-edge allocation of the written register
          // is a newer producer and must stay outstanding.
          if (alloc_valid) pend_d[alloc_addr] = 1'b1;
          if (ZERO_REG != 0) pend_d[0] = 1'b0;
          mem_we = we && !((ZERO_REG != 0) && (waddr == '0));
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      pend_q    <= pend_d;
    end
  end

  // Array has no reset; the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read ports: zero register first, then same-cycle forwarding, then array.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra    = '0;
    rdata = '0;
    rpend = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        ra = raddr[k*ADDR_W +: ADDR_W];
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rdata[k*DATA_W +: DATA_W] = '0;
          rpend[k]                  = 1'b0;
        end else if ((BYPASS != 0) && we && (waddr == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata;
          rpend[k]                  = 1'b0;
        end else begin
          rdata[k*DATA_W +: DATA_W] = mem_q[ra];
          rpend[k]                  = pend_q[ra];
        end
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_req = 1'b0;
  logic             ready;
  logic             we = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rpend;
  logic             alloc_valid = 1'b0;
  logic [AW-1:0]    alloc_addr = '0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  // kind: 0 = rdata[port], 1 = rpend[port], 2 = ready, 3 = act field as given
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  event chk_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: samples the DUT shortly after each check request.
  initial begin
    chk_t it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      #2;
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.kind)
          0:       act = rdata[it.port*DW +: DW];
          1:       act = {31'd0, rpend[it.port]};
          2:       act = {31'd0, ready};
          default: act = it.act;
        endcase
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic exp_rd(input string nm, input int p, input logic [31:0] v);
    chk_t c; c.name = nm; c.kind = 0; c.port = p; c.act = '0; c.exp = v; q.push_back(c);
  endtask
  task automatic exp_pd(input string nm, input int p, input logic v);
    chk_t c; c.name = nm; c.kind = 1; c.port = p; c.act = '0; c.exp = {31'd0, v}; q.push_back(c);
  endtask
  task automatic exp_rdy(input string nm, input logic v);
    chk_t c; c.name = nm; c.kind = 2; c.port = 0; c.act = '0; c.exp = {31'd0, v}; q.push_back(c);
  endtask
  task automatic exp_val(input string nm, input int a, input int e);
    chk_t c; c.name = nm; c.kind = 3; c.port = 0; c.act = a; c.exp = e; q.push_back(c);
  endtask

  task automatic fire();
    -> chk_ev;
    #3;
  endtask

  // Advance one edge; inputs change at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic idle();
    we = 1'b0; alloc_valid = 1'b0; clr_req = 1'b0;
  endtask

  // Counts rising edges until ready; pulses clr_req at edge 5 if asked.
  task automatic count_ready(input string nm, input bit poke_clr);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (poke_clr && n == 5) clr_req = 1'b1;
      if (poke_clr && n == 6) clr_req = 1'b0;
    end
    exp_val(nm, n, 32);
    fire();
    @(negedge clk);
  endtask

  initial begin
    // 1. reset and initial sweep
    @(negedge clk);
    exp_rdy("reset_ready", 1'b0);
    exp_rd("reset_rdata0", 0, 32'h0);
    exp_pd("reset_rpend0", 0, 1'b0);
    fire();
    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    set_ra(5'd3, 5'd3);
    exp_rd("init_rdata0", 0, 32'h0);
    exp_rd("init_rdata1", 1, 32'h0);
    exp_pd("init_rpend0", 0, 1'b0);
    exp_pd("init_rpend1", 1, 1'b0);
    fire();
    count_ready("sweep_edges_rst", 1'b0);
    idle();
    exp_rd("r3_after_init", 0, 32'h0);
    exp_pd("r3_pend_after_init", 1, 1'b0);
    fire();

    // 2. plain write/read and zero register
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; set_ra(5'd1, 5'd2);
    step();
    idle(); set_ra(5'd5, 5'd2);
    exp_rd("r5_read", 0, 32'h12345678);
    fire();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_ra(5'd5, 5'd0);
    exp_rd("r0_zero_same_cycle", 1, 32'h0);
    fire();
    step();
    idle();
    exp_rd("r0_zero_after", 1, 32'h0);
    fire();

    // 3. bypass (r7 pending and holding an older value)
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111; alloc_valid = 1'b1; alloc_addr = 5'd7;
    step();
    idle(); set_ra(5'd7, 5'd7);
    exp_rd("r7_old", 0, 32'h11111111);
    exp_pd("r7_pend_before", 0, 1'b1);
    fire();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    exp_rd("bypass_rdata0", 0, 32'hA5A5A5A5);
    exp_rd("bypass_rdata1", 1, 32'hA5A5A5A5);
    exp_pd("bypass_rpend0", 0, 1'b0);
    exp_pd("bypass_rpend1", 1, 1'b0);
    fire();
    step();
    idle();
    exp_rd("r7_after", 0, 32'hA5A5A5A5);
    exp_pd("r7_pend_cleared", 1, 1'b0);
    fire();

    // 4. scoreboard
    alloc_valid = 1'b1; alloc_addr = 5'd9; set_ra(5'd9, 5'd5);
    step();
    idle();
    exp_pd("alloc_r9", 0, 1'b1);
    exp_pd("r5_not_pend", 1, 1'b0);
    fire();
    we = 1'b1; waddr = 5'd9; wdata = 32'h00000099;
    step();
    idle();
    exp_pd("write_clears_r9", 0, 1'b0);
    exp_rd("r9_data", 0, 32'h00000099);
    fire();
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000009A; alloc_valid = 1'b1; alloc_addr = 5'd9;
    step();
    idle();
    exp_pd("alloc_wins_r9", 0, 1'b1);
    fire();
    alloc_valid = 1'b1; alloc_addr = 5'd0; set_ra(5'd9, 5'd0);
    step();
    idle();
    exp_pd("alloc_r0_ignored", 1, 1'b0);
    fire();

    // 5. clear in RUN with a dropped write, clear during INIT ignored
    clr_req = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h44444444;
    step();
    idle();
    exp_rdy("clr_ready_drop", 1'b0);
    fire();
    count_ready("sweep_edges_clr", 1'b1);
    for (int i = 0; i < 32; i += 2) begin
      set_ra(AW'(i), AW'(i + 1));
      exp_rd($sformatf("clr_r%0d", i), 0, 32'h0);
      exp_rd($sformatf("clr_r%0d", i + 1), 1, 32'h0);
      exp_pd($sformatf("clr_p%0d", i), 0, 1'b0);
      exp_pd($sformatf("clr_p%0d", i + 1), 1, 1'b0);
      fire();
    end

    // 6. async reset in RUN, then mid-sweep at clr_cnt = 10
    alloc_valid = 1'b1; alloc_addr = 5'd12; we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE;
    step();
    idle(); set_ra(5'd12, 5'd12);
    exp_pd("r12_pend_run", 0, 1'b1);
    exp_rd("r12_data_run", 1, 32'h0000CAFE);
    fire();
    rst = 1'b1;
    exp_rdy("rst_run_ready", 1'b0);
    exp_pd("rst_run_rpend", 0, 1'b0);
    exp_rd("rst_run_rdata", 1, 32'h0);
    fire();
    @(negedge clk);
    rst = 1'b0;
    count_ready("sweep_edges_rst2", 1'b0);
    alloc_valid = 1'b1; alloc_addr = 5'd12;
    step();
    idle(); clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    exp_rdy("rst_mid_ready", 1'b0);
    fire();
    @(negedge clk);
    rst = 1'b0;
    count_ready("sweep_edges_mid", 1'b0);
    for (int i = 0; i < 32; i += 2) begin
      set_ra(AW'(i), AW'(i + 1));
      exp_pd($sformatf("mid_p%0d", i), 0, 1'b0);
      exp_pd($sformatf("mid_p%0d", i + 1), 1, 1'b0);
      fire();
    end
    set_ra(5'd12, 5'd3);
    exp_rd("mid_r12_zero", 0, 32'h0);
    fire();

    #20;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-issue 2R1W register file.
- Configurable data width, depth and number of read ports, with optional hardwired zero register and optional write-to-read bypass.
- Adds a per-register pending scoreboard for hazard detection.
- Adds a sequential bulk-clear engine (one entry per cycle), so a large array needs no parallel reset.
- Sits between decode (reads, pending checks, allocation) and writeback (writes) in the core pipeline.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes/allocs.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  request bulk clear of all entries and pending bits.
- ready  out  1  1 = RUN state; writes/allocs accepted.
- we  in  1  write enable (writeback).
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  packed read data, combinational.
- rpend  out  NUM_RD  pending flag of each read port's address, combinational.
- alloc_valid  in  1  mark alloc_addr pending (new in-flight producer).
- alloc_addr  in  ADDR_W  register to mark pending.

Behaviour:
- Clock and reset: one clock domain `clk`; reset `rst` is asynchronous, active-high.
- Reset (asynchronous, immediate):
  - state = INIT, clr_cnt = 0, ready = 0, all pending bits = 0.
  - Array contents are not reset directly; the INIT sweep clears them.
- INIT state:
  - Each rising edge writes 0 to entry clr_cnt, then clr_cnt increments.
  - After the edge that clears entry DEPTH-1, state = RUN and ready = 1.
  - First rising edge after rst deasserts clears entry 0; ready rises DEPTH edges after rst deasserts.
  - we, alloc_valid and clr_req are ignored. rdata = 0 and rpend = 0 on all ports.
- RUN state:
  - Write: if we, and not (ZERO_REG and waddr==0), entry[waddr] <= wdata at the edge.
  - Read: rdata[k] = entry[raddr[k]], combinational, with these overrides:
    - ZERO_REG and raddr[k]==0: rdata[k] = 0.
    - Else if BYPASS and we and waddr==raddr[k]: rdata[k] = wdata (forwarded in the same cycle).
  - All NUM_RD ports may address the same entry; each returns identical data.
- Scoreboard (RUN only):
  - alloc_valid sets pend[alloc_addr] at the edge.
  - we clears pend[waddr] at the edge.
  - Same edge, alloc_addr == waddr: set wins; the newer producer remains outstanding.
  - ZERO_REG: pend[0] is never set.
  - rpend[k] = pend[raddr[k]].
  - If BYPASS and we and waddr==raddr[k]: rpend[k] = 0 in that cycle, since the data is being forwarded.
- clr_req:
  - Sampled in RUN. At the edge: state = INIT, clr_cnt = 0, all pend = 0, ready = 0.
  - A we or alloc_valid in the same cycle as clr_req is dropped.
  - clr_req is ignored in INIT; the sweep is not restarted.
- Reset mid-sweep or mid-operation: returns to INIT at clr_cnt = 0 immediately; any partially cleared state is recleared by the sweep.
- Width rules: addresses are unsigned; no wrap beyond DEPTH-1; clr_cnt is ADDR_W+1 bits wide or uses a terminal compare.

Test Plan:
1. Pulse rst, release; count edges until ready=1 -> exactly 32 edges (defaults). While ready=0, rdata=0 and rpend=0 on both ports even with we=1, waddr=3, wdata=0xDEADBEEF. After ready, entry 3 reads 0.
2. RUN; write 0x12345678 to r5; next cycle raddr0=5 -> 0x12345678. Write 0xFFFFFFFF to r0 -> raddr1=0 reads 0.
3. BYPASS: same cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=raddr1=7 -> both rdata=0xA5A5A5A5, both rpend=0. Old r7 value is not visible.
4. Scoreboard:
   - alloc r9 -> next cycle rpend for r9 = 1.
   - Write r9 -> following cycle rpend = 0.
   - Same-edge alloc r9 + write r9 -> pend stays 1.
   - alloc r0 -> rpend for r0 = 0.
5. clr_req in RUN with we=1 to r4 in the same cycle -> ready drops next cycle, r4 not written. After 32 edges ready=1 and all entries read 0. clr_req during INIT does not extend the sweep.
6. Assert rst at clr_cnt=10 mid-sweep -> ready=0 immediately. After release, a full 32-edge sweep completes; pending bits are all 0.
